// File: rtl/button_reset_conditioner.sv
// button_reset_conditioner: synchronised, debounced push-button with level/edge outputs and a stretched active-low system reset.
// Defining RVX_BUTTON_LONG_PRESS_EN adds LONG_PRESS_CYCLES and a one-shot button_long_press output.
module button_reset_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int SYNC_STAGES        = 2,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter bit BUTTON_ACTIVE_HIGH = 1
`ifdef RVX_BUTTON_LONG_PRESS_EN
    ,
    parameter int LONG_PRESS_CYCLES  = 100000000
`endif
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_level,
    output logic button_pressed,
    output logic button_released,
`ifdef RVX_BUTTON_LONG_PRESS_EN
    output logic button_long_press,
`endif
    output logic system_reset_n
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
    typedef enum logic [1:0] {RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING} state_t;
    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [HW-1:0]          r_hold;
    logic                   r_level, r_pressed, r_released, r_srn;
    logic                   w_level_nxt, w_pressed_nxt, w_released_nxt;
    logic                   w_norm, w_sync_out, w_done;
    assign w_norm     = button_raw ^ !BUTTON_ACTIVE_HIGH;
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_done     = r_cnt == CW'(DEBOUNCE_CYCLES);
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_level_nxt    = r_level;
        w_pressed_nxt  = 1'b0;
        w_released_nxt = 1'b0;
        case (r_state)
            RELEASED: if (w_sync_out) begin
                w_state_nxt = PRESS_PENDING;
                w_cnt_nxt   = CW'(1);
            end
            PRESS_PENDING: if (!w_sync_out) begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end else if (w_done) begin
                w_state_nxt   = PRESSED;
                w_cnt_nxt     = '0;
                w_level_nxt   = 1'b1;
                w_pressed_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            PRESSED: if (!w_sync_out) begin
                w_state_nxt = RELEASE_PENDING;
                w_cnt_nxt   = CW'(1);
            end
            RELEASE_PENDING: if (w_sync_out) begin
                w_state_nxt = PRESSED;
                w_cnt_nxt   = '0;
            end else if (w_done) begin
                w_state_nxt    = RELEASED;
                w_cnt_nxt      = '0;
                w_level_nxt    = 1'b0;
                w_released_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_state    <= RELEASED;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], w_norm};
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_level    <= w_level_nxt;
            r_pressed  <= w_pressed_nxt;
            r_released <= w_released_nxt;
        end
    end
    // A held button keeps the core in reset; the countdown only starts once it is released.
    always_ff @(posedge clock) begin
        if (!reset_n || r_level) begin
            r_hold <= HW'(RESET_HOLD_CYCLES);
            r_srn  <= 1'b0;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
            r_srn  <= r_hold == HW'(1);
        end
    end
`ifdef RVX_BUTTON_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
    logic [LW-1:0] r_lp_cnt;
    logic          r_lp;
    always_ff @(posedge clock) begin
        if (!reset_n || r_state != PRESSED) begin
            r_lp_cnt <= '0;
            r_lp     <= 1'b0;
        end else begin
            r_lp_cnt <= (r_lp_cnt == LW'(LONG_PRESS_CYCLES)) ? r_lp_cnt : r_lp_cnt + 1'b1;
            r_lp     <= r_lp_cnt == LW'(LONG_PRESS_CYCLES - 1);
        end
    end
    assign button_long_press = r_lp;
`endif
    assign button_level    = r_level;
    assign button_pressed  = r_pressed;
    assign button_released = r_released;
    assign system_reset_n  = r_srn;
endmodule

// File: doc/button_reset_conditioner.md
Name: button_reset_conditioner

Overview:
- Board-level stage directly upstream of the microcontroller's active-low reset input.
- Synchronises and debounces a raw push-button, then produces clean level and edge indications.
- Generates a stretched, glitch-free active-low system reset for the core's reset_n port.
- Runs in the divided core clock domain and replaces single-flop button sampling in board tops.

Parameters:
DEBOUNCE_CYCLES, 500000, stable-sample count required to accept a button change (10 ms at 50 MHz); minimum 2
SYNC_STAGES, 2, flip-flop stages in the input synchroniser; minimum 2
RESET_HOLD_CYCLES, 16, cycles system_reset_n stays low after the release/reset condition clears; minimum 1
BUTTON_ACTIVE_HIGH, 1, 1: pressed = button_raw high; 0: pressed = button_raw low

Ports:
clock  input  1  block clock (core clock domain)
reset_n  input  1  synchronous, active-low reset
button_raw  input  1  asynchronous raw button pin
button_level  output  1  debounced pressed level (1 = pressed)
button_pressed  output  1  one-cycle pulse on accepted press
button_released  output  1  one-cycle pulse on accepted release
system_reset_n  output  1  stretched active-low reset for downstream core

Behaviour:
- Interface: one clock, named clock. Reset is synchronous and active-low, named reset_n. No asynchronous reset paths.
- Polarity is normalised first: pressed = button_raw XOR !BUTTON_ACTIVE_HIGH. The normalised value feeds the SYNC_STAGES chain; sync_out is the last stage.
- Reset (reset_n low at an edge):
  - Sync chain = 0 (released).
  - FSM = RELEASED, debounce counter = 0.
  - button_level, button_pressed, button_released = 0.
  - system_reset_n = 0; hold counter = RESET_HOLD_CYCLES.
- FSM states: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
  - RELEASED: sync_out=1 -> PRESS_PENDING, counter=1.
  - PRESS_PENDING: sync_out=0 -> RELEASED, counter=0 (bounce rejected, no pulse). Else counter==DEBOUNCE_CYCLES -> PRESSED, button_level=1, button_pressed=1 for that one cycle. Else counter+1.
  - PRESSED / RELEASE_PENDING: mirror of the above with sync_out polarity inverted. Acceptance sets button_level=0 and pulses button_released.
- Counter width is $clog2(DEBOUNCE_CYCLES+1) and it saturates, never wraps.
- Latency: for a clean transition held stable, button_level changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new button_raw value. The pulse coincides with that level change.
- button_pressed and button_released are never high in the same cycle, and each is high for at most one consecutive cycle.
- Reset hold:
  - While reset_n=0 or button_level=1: system_reset_n=0 and the hold counter reloads to RESET_HOLD_CYCLES.
  - Otherwise the counter decrements each cycle. system_reset_n goes 1 on the edge where it reaches 0, then stays 1.
  - Result: after reset_n rises with the button idle, system_reset_n rises on exactly the RESET_HOLD_CYCLES-th edge.
- A new press during the hold countdown reloads the counter and keeps system_reset_n low.
- system_reset_n is a registered output and never glitches.
- Reset mid-debounce aborts the pending transition with no pulse emitted.

Optional Feature:
- Macro RVX_BUTTON_LONG_PRESS_EN enables parameter LONG_PRESS_CYCLES (default 100000000) and output port button_long_press (1 bit).
- Behaviour with macro defined:
  - While in PRESSED, a saturating counter runs. When it reaches LONG_PRESS_CYCLES, button_long_press pulses for one cycle, once per press.
  - The counter clears on leaving PRESSED or on reset. button_long_press resets to 0.
- Without the macro: the port, parameter and counter are absent; all other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_HOLD_CYCLES=3.
- Power-on: reset_n low 5 cycles then high, button idle -> system_reset_n=0 during reset and rises on the 3rd edge after reset_n=1; button_level=0 and pulses=0 throughout.
- Clean press: button_raw 0->1 held 20 cycles -> button_level=1 and a single button_pressed pulse exactly 6 edges after the first sampling edge; system_reset_n=0 from then on.
- Bounce rejection: button_raw high 3 cycles, low 1, high 3, low -> button_level stays 0 and no pulses; high held steady afterwards -> accepted 6 edges after its last rise.
- Release and hold: from pressed, button_raw->0 stable -> button_released pulse 6 edges later, then system_reset_n rises 3 edges after button_level falls.
- Reset mid-debounce: reset_n low while in PRESS_PENDING with counter=2 -> next edge state RELEASED, no pulse, system_reset_n=0, hold counter=3.
- BUTTON_ACTIVE_HIGH=0, button_raw 1->0 held -> button_level=1 after 6 edges.
- With RVX_BUTTON_LONG_PRESS_EN and LONG_PRESS_CYCLES=10, button held 30 cycles -> exactly one button_long_press pulse, 10 cycles after button_level rises.
